// File: rtl/uni2bin_acc_array.sv
// uni2bin_acc_array: converts NUM unary bitstreams back into binary counts.
// All lanes share one window counter that spans 2^CWID enabled cycles, so
// every lane closes its window on the same cycle. A one-stage input register
// (en_buf/bit_buf) sits ahead of the per-lane accumulators.
//
// Ports:
//   clk     - clock, all state on rising edge
//   rst     - asynchronous active-high reset
//   enable  - bitIn carries a valid stream bit this cycle
//   clear   - synchronous window abort (discards buffered and current bits)
//   bitIn   - one unary bit per lane
//   result  - per-lane count latched at the last completed window
//   valid   - one-cycle pulse, result updated on this edge
//   winCnt  - enabled bits accumulated so far in the current window
`timescale 1ns/1ps

module uni2bin_acc_array #(
  parameter int unsigned CWID = 10,
  parameter int          NUM  = 8,
  parameter int unsigned OWID = CWID + 1,
  localparam int unsigned LANES = (NUM < 1) ? 1 : NUM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              clear,
  input  logic [LANES-1:0]  bitIn,
  output logic [OWID-1:0]   result [LANES],
  output logic              valid,
  output logic [CWID-1:0]   winCnt
);

  localparam logic [CWID-1:0] WIN_LAST = '1;

  logic             en_buf;
  logic [LANES-1:0] bit_buf;
  logic [CWID-1:0]  acc [LANES];

  // Accumulate only when a buffered bit is valid and no abort is in progress;
  // an abort therefore also suppresses a window close in the same cycle.
  logic advance_c;
  logic close_c;
  assign advance_c = en_buf & ~clear;
  assign close_c   = advance_c & (winCnt == WIN_LAST);

  // Input register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_buf  <= 1'b0;
      bit_buf <= '0;
    end else begin
      en_buf  <= enable & ~clear;
      bit_buf <= bitIn;
    end
  end

  // Shared window counter and close pulse; the counter wraps to 0 on close
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      winCnt <= '0;
      valid  <= 1'b0;
    end else begin
      valid <= close_c;
      if (clear) begin
        winCnt <= '0;
      end else if (advance_c) begin
        winCnt <= winCnt + CWID'(1);
      end
    end
  end

  // Per-lane accumulators and result latches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(LANES); i++) begin
        acc[i]    <= '0;
        result[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (clear || close_c) begin
          acc[i] <= '0;
        end else if (advance_c) begin
          acc[i] <= acc[i] + CWID'(bit_buf[i]);
        end
        // Closing add is done at OWID bits so a full window (2^CWID) fits
        if (close_c) begin
          result[i] <= OWID'(acc[i]) + OWID'(bit_buf[i]);
        end
      end
    end
  end

endmodule

// File: tb/tb_uni2bin_acc_array.sv
// Directed bench for uni2bin_acc_array with CWID=4, NUM=4.
`timescale 1ns/1ps

module tb_uni2bin_acc_array;

  localparam int unsigned CWID = 4;
  localparam int          NUM  = 4;
  localparam int unsigned OWID = 5;
  localparam int          WIN  = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic            clear;
  logic [3:0]      bitIn;
  logic [OWID-1:0] result [NUM];
  logic            valid;
  logic [CWID-1:0] winCnt;

  int checks   = 0;
  int failures = 0;

  // Expected pipeline state: previous step left a bit in the input register
  bit m_pend;
  int m_wc;
  int cyc;
  int last_valid_cyc;

  always #5 clk = ~clk;

  uni2bin_acc_array #(.CWID(CWID), .NUM(NUM), .OWID(OWID)) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .clear  (clear),
    .bitIn  (bitIn),
    .result (result),
    .valid  (valid),
    .winCnt (winCnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then check valid and winCnt after the edge
  task automatic step(input logic en, input logic [3:0] b, input logic clr, input string tag);
    logic exp_v;
    enable = en;
    bitIn  = b;
    clear  = clr;
    @(posedge clk);
    #1;
    cyc++;
    exp_v = 1'b0;
    if (clr) begin
      m_wc = 0;
    end else if (m_pend) begin
      if (m_wc == WIN - 1) begin
        m_wc  = 0;
        exp_v = 1'b1;
      end else begin
        m_wc++;
      end
    end
    m_pend = en && !clr;
    chk({tag, " valid"}, 32'(valid), 32'(exp_v));
    chk({tag, " winCnt"}, 32'(winCnt), 32'(m_wc));
    if (valid === 1'b1) last_valid_cyc = cyc;
  endtask

  // lane0 ones, lane1 zeros, lane2 alternating, lane3 a single leading one
  function automatic logic [3:0] t1_bits(input int j);
    return {(j == 0), (j % 2 == 0), 1'b0, 1'b1};
  endfunction

  function automatic bit is_gap(input int s);
    return (s == 2) || (s == 5) || (s == 9) || (s == 13) || (s == 17);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int t0;
    int j;
    logic l0;

    rst = 1'b1; enable = 1'b0; clear = 1'b0; bitIn = '0;
    m_pend = 1'b0; m_wc = 0; cyc = 0; last_valid_cyc = -1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NUM; i++) chk("reset result", 32'(result[i]), 0);
    chk("reset valid", 32'(valid), 0);
    chk("reset winCnt", 32'(winCnt), 0);
    @(negedge clk);
    rst = 1'b0;

    // Test 1: uninterrupted window
    t0 = cyc;
    for (int k = 0; k < 16; k++) step(1'b1, t1_bits(k), 1'b0, "t1");
    step(1'b0, 4'b0000, 1'b0, "t1 close");
    chk("t1 valid cycle", last_valid_cyc - t0, 17);
    chk("t1 lane0", 32'(result[0]), 16);
    chk("t1 lane1", 32'(result[1]), 0);
    chk("t1 lane2", 32'(result[2]), 8);
    chk("t1 lane3", 32'(result[3]), 1);
    chk("t1 winCnt zero", 32'(winCnt), 0);

    // Test 3: three back-to-back windows on lane0 (ones, zeros, alternating)
    t0 = cyc;
    for (int w = 0; w < 3; w++) begin
      for (int k = 0; k < 16; k++) begin
        l0 = (w == 0) ? 1'b1 : (w == 1) ? 1'b0 : logic'(k % 2 == 0);
        step(1'b1, {3'b000, l0}, 1'b0, "t3");
        if (w == 1 && k == 0) begin
          chk("t3 win0 lane0", 32'(result[0]), 16);
          chk("t3 win0 cycle", last_valid_cyc - t0, 17);
        end
        if (w == 2 && k == 0) begin
          chk("t3 win1 lane0", 32'(result[0]), 0);
          chk("t3 win1 cycle", last_valid_cyc - t0, 33);
        end
      end
    end
    step(1'b0, 4'b0000, 1'b0, "t3 close");
    chk("t3 win2 lane0", 32'(result[0]), 8);
    chk("t3 win2 cycle", last_valid_cyc - t0, 49);
    chk("t3 lane3", 32'(result[3]), 0);

    // Test 2: same as test 1 with five enable gaps carrying garbage bits
    t0 = cyc;
    j = 0;
    for (int s = 0; s < 21; s++) begin
      if (is_gap(s)) begin
        step(1'b0, 4'b1111, 1'b0, "t2 gap");
      end else begin
        step(1'b1, t1_bits(j), 1'b0, "t2");
        j++;
      end
    end
    step(1'b0, 4'b0000, 1'b0, "t2 close");
    chk("t2 valid cycle", last_valid_cyc - t0, 22);
    chk("t2 lane0", 32'(result[0]), 16);
    chk("t2 lane1", 32'(result[1]), 0);
    chk("t2 lane2", 32'(result[2]), 8);
    chk("t2 lane3", 32'(result[3]), 1);

    // Test 4: clear at enabled cycle 9, then a full all-ones window
    for (int k = 0; k < 8; k++) step(1'b1, 4'b1111, 1'b0, "t4 pre");
    step(1'b1, 4'b1111, 1'b1, "t4 clear");
    chk("t4 hold lane3", 32'(result[3]), 1);
    t0 = cyc;
    for (int k = 0; k < 16; k++) step(1'b1, 4'b1111, 1'b0, "t4");
    chk("t4 hold lane1", 32'(result[1]), 0);
    step(1'b0, 4'b0000, 1'b0, "t4 close");
    chk("t4 valid cycle", last_valid_cyc - t0, 17);
    chk("t4 lane0", 32'(result[0]), 16);
    chk("t4 lane1", 32'(result[1]), 16);
    chk("t4 lane3", 32'(result[3]), 16);

    // Test 5: clear on the cycle the window would close
    for (int k = 0; k < 16; k++) step(1'b1, 4'b0001, 1'b0, "t5");
    step(1'b0, 4'b0000, 1'b1, "t5 clear at close");
    chk("t5 hold lane1", 32'(result[1]), 16);
    chk("t5 winCnt zero", 32'(winCnt), 0);
    step(1'b0, 4'b0000, 1'b0, "t5 after");
    chk("t5 hold lane0", 32'(result[0]), 16);

    // Test 6: async reset while a valid pulse is in flight, mid next window
    for (int k = 0; k < 17; k++) step(1'b1, 4'b0001, 1'b0, "t6 pre");
    chk("t6 pre lane1", 32'(result[1]), 0);
    #2;
    rst = 1'b1;
    #1;
    chk("t6 rst valid", 32'(valid), 0);
    chk("t6 rst winCnt", 32'(winCnt), 0);
    chk("t6 rst lane0", 32'(result[0]), 0);
    #2;
    rst = 1'b0;
    m_pend = 1'b0;
    m_wc   = 0;
    t0 = cyc;
    for (int k = 0; k < 16; k++) step(1'b1, 4'b0001, 1'b0, "t6");
    step(1'b0, 4'b0000, 1'b0, "t6 close");
    chk("t6 valid cycle", last_valid_cyc - t0, 17);
    chk("t6 lane0", 32'(result[0]), 16);
    chk("t6 lane2", 32'(result[2]), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uni2bin_acc_array.md
Name: uni2bin_acc_array

Overview:
- Receive side of the shared-counter unary generator path: a parallel array of accumulators that converts NUM unary bitstreams back into binary counts.
- A single shared window counter spans 2^CWID enabled cycles, so all lanes close their windows on the same cycle.
- Sits at the output of the uBrain unary compute array. It feeds binary results to downstream buffering or activation logic.
- A one-stage input register mirrors the buffered count fan-out on the generator side.

Parameters:
- CWID, 10, window counter width; window length = 2^CWID enabled cycles.
- NUM, 8, number of bitstream lanes (values < 1 treated as 1).
- OWID, CWID+1, result width; must hold 0..2^CWID inclusive.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous active-high reset.
- enable  input  1  current cycle's bitIn is a valid stream bit.
- clear  input  1  synchronous window abort.
- bitIn  input  NUM  one unary bit per lane.
- result  output  NUM x OWID  unpacked array of latched per-lane counts from the last completed window.
- valid  output  1  one-cycle pulse: result updated this cycle.
- winCnt  output  CWID  shared window position (number of enabled bits accumulated in the current window).

Behaviour:
- Reset (async, rst=1):
  - enBuf, bitBuf, every acc, winCnt, every result and valid all go to 0.
  - Outputs hold 0 until the first window completes.
- Stage 1, every edge:
  - enBuf <= enable & ~clear.
  - bitBuf <= bitIn.
- Stage 2, when enBuf=1 and clear=0:
  - acc[i] <= acc[i] + bitBuf[i] for each lane i.
  - winCnt <= winCnt + 1, wrapping at 2^CWID.
- Window close, when enBuf=1 and winCnt = 2^CWID-1:
  - result[i] <= acc[i] + bitBuf[i] (OWID-bit add; no saturation, since max = 2^CWID fits).
  - acc[i] <= 0 and winCnt <= 0.
  - valid <= 1 on the same edge.
- valid is 0 on every other edge.
- Latency:
  - A bit sampled with enable at edge k is accumulated at edge k+1.
  - For an uninterrupted window whose first enable is sampled at edge 0, valid is high after edge 2^CWID and result is stable from that edge.
- Enable gaps:
  - enBuf=0 holds acc and winCnt.
  - Windows count enabled bits, not clock cycles.
- clear=1:
  - At the next edge acc and winCnt go to 0 and enBuf goes to 0.
  - The bit presented in the clear cycle and the bit already in bitBuf are both discarded.
  - result is held and valid=0.
  - clear takes priority over a window close in the same cycle: no valid pulse, result unchanged.
- Back-to-back windows:
  - Accumulation of the next window starts on the edge after the close, with no bubble.
  - A valid pulse occurs every 2^CWID enabled cycles.
- Reset mid-window: all state zeroed immediately, including a held result and a valid pulse in flight.
- Lanes are fully independent; only winCnt and the enable/clear pipeline are shared.
- acc width is CWID bits. It never exceeds 2^CWID-1 before a close.

Test Plan:
- CWID=4, NUM=4, lane0 all ones, lane1 all zeros, lane2 alternating 1/0, lane3 one then fifteen zeros; 16 consecutive enables:
  - result = {16, 0, 8, 1}.
  - Single valid pulse after edge 16.
  - winCnt returns to 0.
- Same stimulus with enable low on 5 scattered cycles (21 cycles total, 16 enabled):
  - Identical results.
  - valid delayed by 5 cycles.
  - winCnt frozen during gaps.
- Three consecutive windows with all-ones lane0, then all-zeros, then alternating:
  - lane0 = 16, 0, 8.
  - valid pulses exactly 16 cycles apart.
- clear asserted at enabled cycle 9 of a window, then 16 all-ones enables:
  - result still holds the previous window value until the new close.
  - New result lane0 = 16.
  - No valid pulse on the clear cycle.
- clear asserted in the same cycle the window would close: no valid pulse, result unchanged, winCnt = 0.
- rst asserted asynchronously mid-window (between edges) after a prior valid result:
  - result, valid and winCnt go to 0 immediately.
  - After release, a fresh 16-enable all-ones window gives result lane0 = 16.
